// File: rtl/synth_pkg.sv
// Shared synth definitions: voice-index width, defaults, FSM states and the
// 128-entry note-to-DDS-increment table (48 kHz sample rate, 32-bit phase).
package synth_pkg;

  localparam int         VOICE_IDX_W        = 8;
  localparam int         NUM_VOICES_DEFAULT = 16;
  localparam logic [7:0] AGE_MAX            = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE_DDS,
    ST_ISSUE_ADSR
  } voice_state_e;

  typedef logic [127:0][31:0] tuning_table_t;

  // Phase increments for C4..B4; other octaves are exact power-of-two shifts.
  function automatic logic [31:0] semitone_inc(input int semi);
    case (semi)
      0:       return 32'd23409862;
      1:       return 32'd24801879;
      2:       return 32'd26276681;
      3:       return 32'd27839173;
      4:       return 32'd29494579;
      5:       return 32'd31248410;
      6:       return 32'd33106538;
      7:       return 32'd35075155;
      8:       return 32'd37160835;
      9:       return 32'd39370534;
      10:      return 32'd41711631;
      default: return 32'd44191929;
    endcase
  endfunction

  function automatic tuning_table_t build_tuning_table();
    tuning_table_t t;
    for (int n = 0; n < 128; n++) begin
      if (n / 12 >= 5) t[n] = semitone_inc(n % 12) << (n / 12 - 5);
      else             t[n] = semitone_inc(n % 12) >> (5 - n / 12);
    end
    return t;
  endfunction

  localparam tuning_table_t TUNING_TABLE = build_tuning_table();
  localparam logic [31:0]   TUNING_A4    = TUNING_TABLE[69];

endpackage

// File: rtl/voice_allocator_if.sv
// MIDI event handshake plus SPI-side voice command bus of the voice allocator.
interface voice_allocator_if;
  logic        i_evt_valid;
  logic        o_evt_ready;
  logic        i_evt_note_on;
  logic [6:0]  i_evt_note;
  logic [6:0]  i_evt_velocity;
  logic        o_SPI_note_status;
  logic [7:0]  o_SPI_voice_index;
  logic [31:0] o_SPI_tuning_code;
  logic [6:0]  o_SPI_velocity;
  logic        o_SPI_flag_dds;
  logic        o_SPI_flag_adsr;
  logic [8:0]  o_active_count;
  logic        o_drop;

  modport master (
    output i_evt_valid, i_evt_note_on, i_evt_note, i_evt_velocity,
    input  o_evt_ready, o_SPI_note_status, o_SPI_voice_index, o_SPI_tuning_code,
           o_SPI_velocity, o_SPI_flag_dds, o_SPI_flag_adsr, o_active_count, o_drop
  );

  modport slave (
    input  i_evt_valid, i_evt_note_on, i_evt_note, i_evt_velocity,
    output o_evt_ready, o_SPI_note_status, o_SPI_voice_index, o_SPI_tuning_code,
           o_SPI_velocity, o_SPI_flag_dds, o_SPI_flag_adsr, o_active_count, o_drop
  );
endinterface

// File: rtl/note_tuning_rom.sv
// Registered 128x32 note-to-phase-increment lookup; output holds between loads.
module note_tuning_rom
  import synth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [6:0]  i_note,
  output logic [31:0] o_code
);

  always_ff @(posedge i_clk) begin
    if (i_reset)     o_code <= '0;
    else if (i_load) o_code <= TUNING_TABLE[i_note];
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial table scan, then DDS/ADSR command strobes.
// Optional build macro VOICE_STEAL_EN steals the oldest voice instead of dropping.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEFAULT
) (
  input logic             i_clk,
  input logic             i_reset,
  voice_allocator_if.slave bus
);

  localparam int             IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W:0] SCAN_LAST = (IDX_W + 1)'(NUM_VOICES);

  voice_state_e          state;
  logic [NUM_VOICES-1:0] active;
  logic [6:0]            note_tab [NUM_VOICES];
  logic [7:0]            age_tab  [NUM_VOICES];
  logic                  ev_on;
  logic [6:0]            ev_note, ev_vel;
  logic [IDX_W:0]        scan_cnt;
  logic [IDX_W-1:0]      scan_idx, same_idx, free_idx, target, pick;
  logic                  same_found, free_found, hit, accept, scan_busy;
  logic                  ready, drop, flag_dds, flag_adsr, note_status;
  logic [7:0]            voice_index;
  logic [6:0]            vel_out;
  logic [8:0]            active_count, active_sum;

  function automatic logic [7:0] sat_inc(input logic [7:0] a);
    return (a == AGE_MAX) ? a : a + 8'd1;
  endfunction

  assign accept    = bus.i_evt_valid && ready;
  assign scan_idx  = scan_cnt[IDX_W-1:0];
  assign scan_busy = (state == ST_SCAN) && (scan_cnt != SCAN_LAST);

  note_tuning_rom u_rom (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (accept),
    .i_note  (bus.i_evt_note),
    .o_code  (bus.o_SPI_tuning_code)
  );

  always_comb begin
    active_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) active_sum = active_sum + 9'(active[v]);
  end

`ifdef VOICE_STEAL_EN
  logic             old_found;
  logic [IDX_W-1:0] old_idx;
  logic [7:0]       old_age;

  // Oldest active voice; strict compare keeps the lowest index on age ties.
  always_ff @(posedge i_clk) begin
    if (i_reset || accept) begin
      old_found <= 1'b0;
      old_idx   <= '0;
      old_age   <= '0;
    end else if (scan_busy && active[scan_idx] &&
                 (!old_found || age_tab[scan_idx] > old_age)) begin
      old_found <= 1'b1;
      old_idx   <= scan_idx;
      old_age   <= age_tab[scan_idx];
    end
  end
`endif

  always_comb begin
    hit  = 1'b0;
    pick = same_idx;
    if (same_found) begin
      hit = 1'b1;
    end else if (ev_on && free_found) begin
      hit  = 1'b1;
      pick = free_idx;
    end
`ifdef VOICE_STEAL_EN
    else if (ev_on && old_found) begin
      hit  = 1'b1;
      pick = old_idx;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      ready        <= 1'b0;
      drop         <= 1'b0;
      flag_dds     <= 1'b0;
      flag_adsr    <= 1'b0;
      note_status  <= 1'b0;
      voice_index  <= '0;
      vel_out      <= '0;
      active_count <= '0;
      active       <= '0;
      ev_on        <= 1'b0;
      ev_note      <= '0;
      ev_vel       <= '0;
      scan_cnt     <= '0;
      same_found   <= 1'b0;
      free_found   <= 1'b0;
      same_idx     <= '0;
      free_idx     <= '0;
      target       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_tab[v] <= '0;
        age_tab[v]  <= '0;
      end
    end else begin
      flag_dds     <= 1'b0;
      flag_adsr    <= 1'b0;
      drop         <= 1'b0;
      active_count <= active_sum;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            ev_on      <= bus.i_evt_note_on && (bus.i_evt_velocity != 7'd0);
            ev_note    <= bus.i_evt_note;
            ev_vel     <= bus.i_evt_velocity;
            scan_cnt   <= '0;
            same_found <= 1'b0;
            free_found <= 1'b0;
            ready      <= 1'b0;
            state      <= ST_SCAN;
          end else begin
            ready <= 1'b1;
          end
        end
        // One voice examined per cycle; the extra final cycle resolves the target.
        ST_SCAN: begin
          if (scan_busy) begin
            if (active[scan_idx] && note_tab[scan_idx] == ev_note && !same_found) begin
              same_found <= 1'b1;
              same_idx   <= scan_idx;
            end
            if (!active[scan_idx] && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= scan_idx;
            end
            scan_cnt <= scan_cnt + (IDX_W + 1)'(1);
          end else if (hit) begin
            target      <= pick;
            voice_index <= VOICE_IDX_W'(pick);
            note_status <= ev_on;
            vel_out     <= ev_vel;
            state       <= ev_on ? ST_ISSUE_DDS : ST_ISSUE_ADSR;
          end else begin
            drop  <= ev_on;
            ready <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_ISSUE_DDS: begin
          flag_dds <= 1'b1;
          state    <= ST_ISSUE_ADSR;
        end
        ST_ISSUE_ADSR: begin
          flag_adsr <= 1'b1;
          if (ev_on) begin
            active[target]   <= 1'b1;
            note_tab[target] <= ev_note;
            for (int v = 0; v < NUM_VOICES; v++)
              age_tab[v] <= (IDX_W'(v) == target) ? '0 : sat_inc(age_tab[v]);
          end else begin
            active[target] <= 1'b0;
          end
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_evt_ready       = ready;
  assign bus.o_SPI_note_status = note_status;
  assign bus.o_SPI_voice_index = voice_index;
  assign bus.o_SPI_velocity    = vel_out;
  assign bus.o_SPI_flag_dds    = flag_dds;
  assign bus.o_SPI_flag_adsr   = flag_adsr;
  assign bus.o_active_count    = active_count;
  assign bus.o_drop            = drop;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with NUM_VOICES=4; expectations follow VOICE_STEAL_EN.
module tb_voice_allocator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_allocator_if bus ();

  voice_allocator #(.NUM_VOICES(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          dds_cnt, adsr_cnt, drop_cnt, dds_cyc, adsr_cyc, drop_cyc;
  logic [7:0]  dds_idx, adsr_idx;
  logic [31:0] dds_code, adsr_code;
  logic        adsr_status;
  logic [6:0]  adsr_vel;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    dds_cnt = 0; adsr_cnt = 0; drop_cnt = 0;
    dds_cyc = 0; adsr_cyc = 0; drop_cyc = 0;
    dds_idx = '0; adsr_idx = '0; dds_code = '0; adsr_code = '0;
    adsr_status = 1'b0; adsr_vel = '0;
  endtask

  // Advance to the next falling edge and record any strobe seen in cycle c.
  task automatic tick(input int c);
    @(negedge clk);
    if (bus.o_SPI_flag_dds) begin
      dds_cnt++; dds_cyc = c;
      dds_idx = bus.o_SPI_voice_index; dds_code = bus.o_SPI_tuning_code;
    end
    if (bus.o_SPI_flag_adsr) begin
      adsr_cnt++; adsr_cyc = c;
      adsr_idx = bus.o_SPI_voice_index; adsr_code = bus.o_SPI_tuning_code;
      adsr_status = bus.o_SPI_note_status; adsr_vel = bus.o_SPI_velocity;
    end
    if (bus.o_drop) begin
      drop_cnt++; drop_cyc = c;
    end
  endtask

  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
    int waitc;
    waitc = 0;
    clear_mon();
    @(negedge clk);
    bus.i_evt_valid    = 1'b1;
    bus.i_evt_note_on  = on;
    bus.i_evt_note     = note;
    bus.i_evt_velocity = vel;
    while (!bus.o_evt_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("ready_before_accept", bus.o_evt_ready, 1);
    @(posedge clk);
    #1 bus.i_evt_valid = 1'b0;
    for (int c = 1; c <= 14; c++) tick(c);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_evt_valid = 1'b0; bus.i_evt_note_on = 1'b0;
    bus.i_evt_note = '0; bus.i_evt_velocity = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_low", bus.o_evt_ready, 0);
    check("rst_active_count", bus.o_active_count, 0);
    check("rst_tuning_code", bus.o_SPI_tuning_code, 0);
    check("rst_flags", {bus.o_SPI_flag_dds, bus.o_SPI_flag_adsr, bus.o_drop}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.o_evt_ready, 1);

    // Note-on A4 into an empty table
    send(1'b1, 7'd69, 7'd100);
    check("a4_dds_cycle", dds_cyc, 7);
    check("a4_dds_voice", dds_idx, 0);
    check("a4_dds_code", dds_code, 32'd39370534);
    check("a4_adsr_cycle", adsr_cyc, 8);
    check("a4_adsr_status", adsr_status, 1);
    check("a4_adsr_vel", adsr_vel, 100);
    check("a4_adsr_voice_hold", adsr_idx, 0);
    check("a4_adsr_code_hold", adsr_code, 32'd39370534);
    check("a4_strobe_counts", {dds_cnt[7:0], adsr_cnt[7:0]}, {8'd1, 8'd1});
    check("a4_active_count", bus.o_active_count, 1);

    send(1'b1, 7'd60, 7'd90);
    check("n60_voice", dds_idx, 1);
    check("n60_code", dds_code, 32'd23409862);
    send(1'b1, 7'd62, 7'd80);
    check("n62_voice", adsr_idx, 2);
    send(1'b1, 7'd64, 7'd70);
    check("n64_voice", adsr_idx, 3);
    check("four_active", bus.o_active_count, 4);

    // Note-off 62: single ADSR strobe, gate off, voice 2
    send(1'b0, 7'd62, 7'd0);
    check("off62_dds_cnt", dds_cnt, 0);
    check("off62_adsr_cnt", adsr_cnt, 1);
    check("off62_adsr_cycle", adsr_cyc, 7);
    check("off62_voice", adsr_idx, 2);
    check("off62_status", adsr_status, 0);
    check("off62_active_count", bus.o_active_count, 3);

    // Velocity-0 note-on behaves as note-off
    send(1'b1, 7'd60, 7'd0);
    check("vel0_dds_cnt", dds_cnt, 0);
    check("vel0_voice", adsr_idx, 1);
    check("vel0_status", adsr_status, 0);
    check("vel0_active_count", bus.o_active_count, 2);

    // Note-off for a note never played
    send(1'b0, 7'd50, 7'd0);
    check("off50_strobes", {dds_cnt[7:0], adsr_cnt[7:0], drop_cnt[7:0]}, 0);
    check("off50_active_count", bus.o_active_count, 2);

    // Fill all four voices from a clean table, then a fifth note-on
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int n = 60; n < 64; n++) send(1'b1, 7'(n), 7'd64);
    check("full_last_voice", adsr_idx, 3);
    check("full_active_count", bus.o_active_count, 4);
    send(1'b1, 7'd64, 7'd55);
`ifdef VOICE_STEAL_EN
    check("steal_dds_voice", dds_idx, 0);
    check("steal_adsr_voice", adsr_idx, 0);
    check("steal_status", adsr_status, 1);
    check("steal_no_drop", drop_cnt, 0);
`else
    check("drop_cnt", drop_cnt, 1);
    check("drop_cycle", drop_cyc, 6);
    check("drop_no_strobes", {dds_cnt[7:0], adsr_cnt[7:0]}, 0);
`endif
    check("fifth_active_count", bus.o_active_count, 4);

    // Retrigger: note 61 is still held by voice 1
    send(1'b1, 7'd61, 7'd33);
    check("retrig_voice", dds_idx, 1);
    check("retrig_code", dds_code, 32'd24801879);
    check("retrig_active_count", bus.o_active_count, 4);

    // Reset while scanning aborts the event
    clear_mon();
    @(negedge clk);
    bus.i_evt_valid = 1'b1; bus.i_evt_note_on = 1'b1;
    bus.i_evt_note = 7'd70; bus.i_evt_velocity = 7'd90;
    check("abort_ready_before", bus.o_evt_ready, 1);
    @(posedge clk);
    #1 bus.i_evt_valid = 1'b0;
    tick(1); tick(2);
    rst = 1'b1;
    tick(3); tick(4);
    check("abort_ready_in_rst", bus.o_evt_ready, 0);
    check("abort_count_in_rst", bus.o_active_count, 0);
    rst = 1'b0;
    tick(5);
    check("abort_ready_after", bus.o_evt_ready, 1);
    for (int c = 6; c <= 15; c++) tick(c);
    check("abort_no_strobes", {dds_cnt[7:0], adsr_cnt[7:0], drop_cnt[7:0]}, 0);
    check("abort_active_count", bus.o_active_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter: NUM_VOICES, 16, voice slots managed; power of two, 2..256.
REQ-002 SHALL have ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high; clock i_clk.
- i_evt_valid  in  1  MIDI event present.
- o_evt_ready  out  1  event accepted when valid && ready.
- i_evt_note_on  in  1  1 = note-on, 0 = note-off.
- i_evt_note  in  7  MIDI note number.
- i_evt_velocity  in  7  MIDI velocity.
- o_SPI_note_status  out  1  1 = gate on, 0 = gate off.
- o_SPI_voice_index  out  8  target voice.
- o_SPI_tuning_code  out  32  DDS phase increment.
- o_SPI_velocity  out  7  velocity for the voice.
- o_SPI_flag_dds  out  1  one-cycle DDS write strobe.
- o_SPI_flag_adsr  out  1  one-cycle ADSR write strobe.
- o_active_count  out  9  number of gated voices.
- o_drop  out  1  one-cycle pulse: event discarded.

Function
REQ-003 SHALL keep a per-voice table: active bit, note[6:0], and an age counter saturating at 255.
REQ-004 SHALL implement FSM IDLE -> SCAN -> ISSUE_DDS -> ISSUE_ADSR -> IDLE; o_evt_ready=1 only in IDLE.
REQ-005 SHALL latch note, velocity and type on accept, then enter SCAN.
REQ-006 SHALL treat a note-on with velocity 0 as a note-off.
REQ-007 SHALL, in SCAN, examine one voice per cycle, index 0..NUM_VOICES-1, for exactly NUM_VOICES cycles.
REQ-008 SHALL choose the note-on target in this priority:
- an active voice holding the same note (retrigger);
- otherwise the lowest-index inactive voice;
- otherwise steal per REQ-017.
REQ-009 SHALL choose the note-off target as the lowest-index active voice holding that note.
- If no voice holds the note: no strobes, return to IDLE after SCAN.
REQ-010 SHALL handle note-on as follows:
- ISSUE_DDS: o_SPI_flag_dds=1 with tuning code and voice index valid.
- ISSUE_ADSR: o_SPI_flag_adsr=1 with note_status=1 and velocity.
- Then set the voice active, store its note, clear its age to 0, and increment every other age, saturating.
REQ-011 SHALL handle note-off by skipping ISSUE_DDS: one o_SPI_flag_adsr pulse with note_status=0, then clear the active bit.
REQ-012 SHALL hold SPI data outputs stable from the cycle of flag_dds through the cycle of flag_adsr.
REQ-013 SHALL look up the tuning code with 1-cycle latency from the accept cycle; the result is held until the next accept.
REQ-014 SHALL make event-to-last-strobe latency NUM_VOICES+3 cycles for note-on and NUM_VOICES+2 cycles for note-off.
REQ-015 SHALL update o_active_count in the cycle after the table changes; the count never exceeds NUM_VOICES.

Reset
REQ-016 SHALL, while i_reset is high, regardless of FSM state:
- go to IDLE and clear all active bits, notes and ages;
- drive all outputs to 0, except o_evt_ready, which is 1 in the cycle after reset deasserts;
- abort any in-flight event with no strobes.

Configuration
REQ-017 SHALL, with VOICE_STEAL_EN defined, steal on a note-on when all voices are active:
- target = active voice with maximum age, ties to lowest index;
- issue the normal DDS then ADSR sequence with note_status=1;
- o_drop stays 0.
REQ-018 SHALL, without VOICE_STEAL_EN, discard such a note-on:
- pulse o_drop for one cycle at SCAN end;
- issue no strobes and return to IDLE.

Structure
REQ-019 SHALL take from shared package synth_pkg:
- voice-index width, NUM_VOICES default, AGE_MAX=255;
- the 128-entry tuning table and constant TUNING_A4 (note 69 entry);
- the FSM state enum.
REQ-020 SHALL instantiate exactly one sub-module, note_tuning_rom: registered 128x32 lookup, note in, tuning code out.

Verification
REQ-021 SHALL cover, with NUM_VOICES=4:
- Note-on 69 vel 100 after reset -> at cycle 7 after accept, flag_dds with voice 0 and TUNING_A4; at cycle 8, flag_adsr with status 1, vel 100; active_count=1.
- Note-on 60, 62, 64 then note-off 62 -> voices 1,2,3 used; the off pulses flag_adsr only, voice 2, status 0; no flag_dds.
- Note-on 60 vel 0 while 60 is on voice 1 -> treated as off: voice 1 released, active_count decrements.
- Five note-ons 60..64, VOICE_STEAL_EN defined -> fifth lands on voice 0 (oldest).
- Same five note-ons, macro undefined -> o_drop pulse; no strobes; active_count=4.
- Note-off 50 (never on) -> no strobes. i_reset asserted during SCAN -> no strobes, active_count=0, ready=1 the cycle after release.
